dbscan_cluster_ctrl: RTL and testbench
======================================

Name: dbscan_cluster_ctrl

Overview:
- Sequencer for the DBSCAN point-memory and distance-unit datapath.
- Runs four phases over N stored points in order: clear labels, classify core points (pairwise eps test), breadth-first cluster expansion through an internal seed FIFO, and noise marking.
- Owns every address and write-enable to point memory. The distance unit stays purely combinational.

Parameters:
- N, 16, number of points. Must be a power of two, at least 4.
- IDX_W, 4, point index width, log2(N).
- LBL_W, 4, label width. Label 0 = unclassified; label all-ones (4'hF) = noise; labels 1..14 = cluster ids.
- EPS2, 18'd100, squared eps radius. A pair is a neighbour when dist2 <= EPS2.
- MINPTS, 3, minimum neighbour count for a core point. The count includes the point itself.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  one-cycle start pulse. Accepted only in IDLE or DONE.
- dist2  input  18  squared distance between point i and point j, same cycle.
- l_i  input  LBL_W  label of point i, combinational read.
- l_j  input  LBL_W  label of point j, combinational read.
- core_i  input  1  core flag of point i.
- core_j  input  1  core flag of point j.
- i  output  IDX_W  read address A.
- j  output  IDX_W  read address B.
- we_label  output  1  label write enable.
- we_core  output  1  core-flag write enable.
- waddr  output  IDX_W  write address.
- wlabel  output  LBL_W  label write data.
- wcore  output  1  core write data.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE.
- n_clusters  output  LBL_W  number of clusters created.
- overflow  output  1  sticky; set when more than 14 clusters were required.

Behaviour:
- Reset (rst=0 at an edge):
  - state = IDLE.
  - All outputs 0; i, j, n_clusters, overflow, FIFO pointers and count all cleared.
  - Reset mid-run abandons the run immediately; no further writes occur.
- Memory model: reads are combinational. A write issued in cycle t is visible to reads in cycle t+1.
- States: IDLE, CLEAR, CORE, SEED, EXPAND, POP, NOISE, DONE.
- IDLE / DONE:
  - On start: i=0, n_clusters=0, overflow=0, go to CLEAR.
  - done stays high in DONE until start or reset.
- CLEAR (N cycles):
  - Each cycle: we_label=1, we_core=1, waddr=i, wlabel=0, wcore=0; i increments.
  - After i=N-1: i=0, j=0, cnt=0, go to CORE.
- CORE (N*N cycles, one pair per cycle):
  - hit = (dist2 <= EPS2). cnt is IDX_W+1 bits and accumulates hits.
  - When j=N-1: we_core=1, waddr=i, wcore=((cnt+hit) >= MINPTS). Then cnt=0 and j wraps to 0.
  - Otherwise j increments.
  - After the (N-1,N-1) pair: i=0, go to SEED.
- SEED (one cycle per candidate i):
  - If l_i==0 and core_i==1, a new cluster starts:
    - If n_clusters<14, increment it; otherwise hold it at 14 and set overflow.
    - we_label=1, waddr=i, wlabel = new id (14 when saturated).
    - Push i, set j=0, go to EXPAND. The seed index is retained for resume.
  - Otherwise advance i. After i=N-1: i=0, go to NOISE.
- EXPAND (N cycles, scanning j with i = current point p):
  - If hit and l_j==0: we_label=1, waddr=j, wlabel = current id. If core_j, also push j.
  - A point is labelled and pushed at most once, so the FIFO (depth N) never overflows. A push into a full FIFO is a design error; the bench asserts it.
  - After j=N-1, go to POP.
- POP (1 cycle):
  - FIFO non-empty: pop the head into i, j=0, go to EXPAND.
  - FIFO empty: restore i = seed+1 and return to SEED. If seed = N-1, set i=0 and go to NOISE instead.
  - Push and pop never occur in the same cycle.
- NOISE (N cycles):
  - Each i with l_i==0 gets we_label=1, waddr=i, wlabel=4'hF.
  - After i=N-1, go to DONE.
- we_label and we_core are never both high except in CLEAR.
- All write signals are registered-free combinational decodes of the state and index registers. They are valid in the same cycle as the read data.

Test Plan:
- All 16 points at (5,5,5), MINPTS=3 -> every wcore=1; one cluster; all labels 1; n_clusters=1; done after 16+256+SEED/EXPAND cycles.
- Points 0-7 at (0,0,0), points 8-15 at (200,200,200) -> labels 0-7 = 1, labels 8-15 = 2, n_clusters=2, no noise.
- Points 0-14 at origin, point 15 at (255,255,255) -> label[15]=4'hF; others 1.
- Chain with MINPTS=3: points 0,1,2 within eps of each other; point 3 within eps of point 2 only -> points 0,1,2 core; point 3 non-core border, labelled 1 and never pushed.
- 16 mutually distant points, MINPTS=1 -> 16 seeds; n_clusters saturates at 14; overflow=1; labels 15,16 both 14.
- Reset (rst=0) asserted during EXPAND -> next cycle all write enables 0, busy=0, state IDLE. A fresh start then reproduces the case-2 result.

Source files
------------

// File: rtl/dbscan_cluster_ctrl.sv
// Purpose: sequencer for DBSCAN over N stored points (clear, core classify, BFS expand, noise).
// Latency: N + N*N + expansion + N cycles per run; write strobes are same-cycle decodes of state.
// Backpressure: none; memory and distance unit are combinational, start is ignored while busy.
// Ports: clk/rst (sync, active-low), start; dist2/l_i/l_j/core_i/core_j read data for pair (i,j);
//        i/j read addresses; we_label/we_core/waddr/wlabel/wcore write port; busy/done/n_clusters/overflow.
module dbscan_cluster_ctrl #(
    parameter int          N      = 16,
    parameter int          IDX_W  = 4,
    parameter int          LBL_W  = 4,
    parameter logic [17:0] EPS2   = 18'd100,
    parameter int          MINPTS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [17:0]      dist2,
    input  logic [LBL_W-1:0] l_i,
    input  logic [LBL_W-1:0] l_j,
    input  logic             core_i,
    input  logic             core_j,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic             we_label,
    output logic             we_core,
    output logic [IDX_W-1:0] waddr,
    output logic [LBL_W-1:0] wlabel,
    output logic             wcore,
    output logic             busy,
    output logic             done,
    output logic [LBL_W-1:0] n_clusters,
    output logic             overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_CORE, S_SEED, S_EXPAND, S_POP, S_NOISE, S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [LBL_W-1:0] LBL_ONE  = LBL_W'(1);
    localparam logic [LBL_W-1:0] MAX_ID   = {{(LBL_W-1){1'b1}}, 1'b0};
    localparam logic [IDX_W:0]   MINPTS_C = (IDX_W+1)'(MINPTS);
    localparam logic [IDX_W:0]   FULL_C   = (IDX_W+1)'(N);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d, seed_q, seed_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [LBL_W-1:0] ncl_q, ncl_d;
    logic             ovf_q, ovf_d;

    // Seed FIFO for the breadth-first expansion; depth N is enough because
    // every point is labelled, and therefore pushed, at most once per run.
    logic [IDX_W-1:0] fifo_q [N];
    logic [IDX_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IDX_W:0]   fcnt_q, fcnt_d;
    logic             push, pop, push_ok, flush, fifo_full, fifo_empty;
    logic [IDX_W-1:0] push_dat;

    logic             hit, new_cl;
    logic [IDX_W:0]   cnt_sum;
    logic [LBL_W-1:0] new_id;

    assign hit        = (dist2 <= EPS2);
    assign new_cl     = (l_i == '0) && core_i;
    assign new_id     = (ncl_q < MAX_ID) ? ncl_q + LBL_ONE : MAX_ID;
    assign cnt_sum    = cnt_q + (IDX_W+1)'(hit);
    assign fifo_full  = (fcnt_q == FULL_C);
    assign fifo_empty = (fcnt_q == '0);
    assign push_ok    = push && !fifo_full;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            seed_q  <= '0;
            cnt_q   <= '0;
            ncl_q   <= '0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            ncl_q   <= ncl_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wptr_q] <= push_dat;
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        ncl_d    = ncl_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        push_dat = j_q;
        pop      = 1'b0;
        flush    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    ncl_d   = '0;
                    ovf_d   = 1'b0;
                    flush   = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                i_d = i_q + IDX_ONE;
                if (i_q == LAST) begin
                    i_d     = '0;
                    j_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CORE;
                end
            end
            S_CORE: begin
                if (j_q == LAST) begin
                    cnt_d = '0;
                    j_d   = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        state_d = S_SEED;
                    end else begin
                        i_d = i_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_sum;
                    j_d   = j_q + IDX_ONE;
                end
            end
            S_SEED: begin
                if (new_cl) begin
                    ncl_d    = new_id;
                    if (ncl_q == MAX_ID) ovf_d = 1'b1;
                    push     = 1'b1;
                    push_dat = i_q;
                    seed_d   = i_q;
                    j_d      = '0;
                    state_d  = S_EXPAND;
                end else if (i_q == LAST) begin
                    i_d     = '0;
                    state_d = S_NOISE;
                end else begin
                    i_d = i_q + IDX_ONE;
                end
            end
            S_EXPAND: begin
                // Only core neighbours propagate the cluster; border points are labelled only.
                if (hit && (l_j == '0) && core_j) push = 1'b1;
                j_d = j_q + IDX_ONE;
                if (j_q == LAST) state_d = S_POP;
            end
            S_POP: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    i_d     = fifo_q[rptr_q];
                    j_d     = '0;
                    state_d = S_EXPAND;
                end else if (seed_q == LAST) begin
                    i_d     = '0;
                    state_d = S_NOISE;
                end else begin
                    i_d     = seed_q + IDX_ONE;
                    state_d = S_SEED;
                end
            end
            S_NOISE: begin
                i_d = i_q + IDX_ONE;
                if (i_q == LAST) begin
                    i_d     = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers; push and pop are never in the same cycle by construction.
    always_comb begin
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            fcnt_d = '0;
        end else begin
            wptr_d = wptr_q + IDX_W'(push_ok);
            rptr_d = rptr_q + IDX_W'(pop);
            fcnt_d = fcnt_q + (IDX_W+1)'(push_ok) - (IDX_W+1)'(pop);
        end
    end

    // Output decode
    always_comb begin
        we_label = 1'b0;
        we_core  = 1'b0;
        waddr    = i_q;
        wlabel   = '0;
        wcore    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                we_label = 1'b1;
                we_core  = 1'b1;
            end
            S_CORE: begin
                if (j_q == LAST) begin
                    we_core = 1'b1;
                    wcore   = (cnt_sum >= MINPTS_C);
                end
            end
            S_SEED: begin
                if (new_cl) begin
                    we_label = 1'b1;
                    wlabel   = new_id;
                end
            end
            S_EXPAND: begin
                if (hit && (l_j == '0)) begin
                    we_label = 1'b1;
                    waddr    = j_q;
                    wlabel   = ncl_q;
                end
            end
            S_NOISE: begin
                if (l_i == '0) begin
                    we_label = 1'b1;
                    wlabel   = '1;
                end
            end
            default: ;
        endcase
    end

    assign i          = i_q;
    assign j          = j_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign n_clusters = ncl_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_dbscan_cluster_ctrl.sv
// Purpose: directed bench for dbscan_cluster_ctrl with behavioural point/label memories.
// Latency: checks busy-cycle totals computed by hand for each scenario.
// Backpressure: none; inputs driven and outputs sampled on the falling edge.
module tb_dbscan_cluster_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1;
    logic [7:0] px [16];
    logic [7:0] py [16];
    logic [7:0] pz [16];
    logic [3:0] lbl0 [16];
    logic [3:0] lbl1 [16];
    logic       cor0 [16];
    logic       cor1 [16];

    logic [17:0] dist2_0, dist2_1;
    logic [3:0]  l_i0, l_j0, l_i1, l_j1;
    logic        core_i0, core_j0, core_i1, core_j1;
    logic [3:0]  i0, j0, waddr0, wlabel0, ncl0, i1, j1, waddr1, wlabel1, ncl1;
    logic        we_label0, we_core0, wcore0, busy0, done0, ovf0;
    logic        we_label1, we_core1, wcore1, busy1, done1, ovf1;

    int checks = 0;
    int errors = 0;

    function automatic logic [17:0] d2(input logic [7:0] ax, ay, az, bx, by, bz);
        int dx, dy, dz;
        dx = int'(ax) - int'(bx);
        dy = int'(ay) - int'(by);
        dz = int'(az) - int'(bz);
        return 18'(dx * dx + dy * dy + dz * dz);
    endfunction

    always_comb dist2_0 = d2(px[i0], py[i0], pz[i0], px[j0], py[j0], pz[j0]);
    always_comb dist2_1 = d2(px[i1], py[i1], pz[i1], px[j1], py[j1], pz[j1]);
    assign l_i0 = lbl0[i0];
    assign l_j0 = lbl0[j0];
    assign core_i0 = cor0[i0];
    assign core_j0 = cor0[j0];
    assign l_i1 = lbl1[i1];
    assign l_j1 = lbl1[j1];
    assign core_i1 = cor1[i1];
    assign core_j1 = cor1[j1];

    always @(posedge clk) begin
        if (we_label0) lbl0[waddr0] <= wlabel0;
        if (we_core0)  cor0[waddr0] <= wcore0;
        if (we_label1) lbl1[waddr1] <= wlabel1;
        if (we_core1)  cor1[waddr1] <= wcore1;
    end

    dbscan_cluster_ctrl #(.MINPTS(3)) u0 (
        .clk(clk), .rst(rst), .start(start0), .dist2(dist2_0),
        .l_i(l_i0), .l_j(l_j0), .core_i(core_i0), .core_j(core_j0),
        .i(i0), .j(j0), .we_label(we_label0), .we_core(we_core0),
        .waddr(waddr0), .wlabel(wlabel0), .wcore(wcore0),
        .busy(busy0), .done(done0), .n_clusters(ncl0), .overflow(ovf0)
    );

    dbscan_cluster_ctrl #(.MINPTS(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .dist2(dist2_1),
        .l_i(l_i1), .l_j(l_j1), .core_i(core_i1), .core_j(core_j1),
        .i(i1), .j(j1), .we_label(we_label1), .we_core(we_core1),
        .waddr(waddr1), .wlabel(wlabel1), .wcore(wcore1),
        .busy(busy1), .done(done1), .n_clusters(ncl1), .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lvec(input int sel);
        logic [63:0] v;
        for (int k = 0; k < 16; k++) v[4*k +: 4] = (sel == 0) ? lbl0[k] : lbl1[k];
        return v;
    endfunction

    function automatic logic [15:0] cvec(input int sel);
        logic [15:0] v;
        for (int k = 0; k < 16; k++) v[k] = (sel == 0) ? cor0[k] : cor1[k];
        return v;
    endfunction

    // Pulses start, counts busy cycles and cycles with both write enables high,
    // and flags any push into a full seed FIFO.
    task automatic run(input int sel, output int cyc, output int both, output logic fovf);
        int it;
        cyc = 0; both = 0; fovf = 1'b0; it = 0;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        while (((sel == 0) ? !done0 : !done1) && it < 4000) begin
            if (sel == 0) begin
                if (busy0) cyc++;
                if (we_label0 && we_core0) both++;
                if (u0.push && u0.fifo_full) fovf = 1'b1;
            end else begin
                if (busy1) cyc++;
                if (we_label1 && we_core1) both++;
                if (u1.push && u1.fifo_full) fovf = 1'b1;
            end
            it++;
            @(negedge clk);
        end
        chk("run_done", (sel == 0) ? done0 : done1, 1);
    endtask

    task automatic set_two_groups();
        for (int k = 0; k < 16; k++) begin
            px[k] = (k < 8) ? 8'd0 : 8'd200;
            py[k] = px[k];
            pz[k] = px[k];
        end
    endtask

    int cyc, both;
    logic fovf;

    initial begin
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            px[k] = 8'd0; py[k] = 8'd0; pz[k] = 8'd0;
            lbl0[k] = 4'd0; lbl1[k] = 4'd0; cor0[k] = 1'b0; cor1[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_i", i0, 0);
        chk("rst_j", j0, 0);
        chk("rst_we_label", we_label0, 0);
        chk("rst_we_core", we_core0, 0);
        chk("rst_ncl", ncl0, 0);
        chk("rst_ovf", ovf0, 0);
        rst = 1'b1;
        @(negedge clk);

        // All points coincident: one cluster, everything core.
        for (int k = 0; k < 16; k++) begin px[k] = 8'd5; py[k] = 8'd5; pz[k] = 8'd5; end
        run(0, cyc, both, fovf);
        chk("c1_labels", lvec(0), 64'h1111_1111_1111_1111);
        chk("c1_core", cvec(0), 16'hFFFF);
        chk("c1_ncl", ncl0, 1);
        chk("c1_ovf", ovf0, 0);
        chk("c1_cycles", cyc, 593);
        chk("c1_both_we", both, 16);
        chk("c1_fifo_full_push", fovf, 0);
        repeat (2) @(negedge clk);
        chk("c1_done_hold", done0, 1);
        chk("c1_busy_idle", busy0, 0);

        // Two well separated groups of eight.
        set_two_groups();
        run(0, cyc, both, fovf);
        chk("c2_labels", lvec(0), 64'h2222_2222_1111_1111);
        chk("c2_core", cvec(0), 16'hFFFF);
        chk("c2_ncl", ncl0, 2);
        chk("c2_cycles", cyc, 610);
        chk("c2_fifo_full_push", fovf, 0);

        // One outlier becomes noise.
        for (int k = 0; k < 16; k++) begin
            px[k] = (k == 15) ? 8'd255 : 8'd0; py[k] = px[k]; pz[k] = px[k];
        end
        run(0, cyc, both, fovf);
        chk("c3_labels", lvec(0), 64'hF111_1111_1111_1111);
        chk("c3_core", cvec(0), 16'h7FFF);
        chk("c3_ncl", ncl0, 1);
        chk("c3_cycles", cyc, 576);

        // Chain: 0,1,2 core; 3 is a border point exactly at eps from 2.
        for (int k = 0; k < 16; k++) begin py[k] = 8'd0; pz[k] = 8'd0; end
        px[0] = 8'd0; px[1] = 8'd1; px[2] = 8'd2; px[3] = 8'd12;
        for (int k = 4; k < 16; k++) px[k] = 8'(30 + (k - 4) * 15);
        run(0, cyc, both, fovf);
        chk("c4_labels", lvec(0), 64'hFFFF_FFFF_FFFF_1111);
        chk("c4_core", cvec(0), 16'h0007);
        chk("c4_ncl", ncl0, 1);
        chk("c4_cycles", cyc, 372);

        // Sixteen isolated points with MINPTS=1: cluster ids saturate at 14.
        for (int k = 0; k < 16; k++) begin px[k] = 8'(k * 16); py[k] = 8'd0; pz[k] = 8'd0; end
        run(1, cyc, both, fovf);
        chk("c5_labels", lvec(1), 64'hEEED_CBA9_8765_4321);
        chk("c5_core", cvec(1), 16'hFFFF);
        chk("c5_ncl", ncl1, 14);
        chk("c5_ovf", ovf1, 1);
        chk("c5_cycles", cyc, 848);
        chk("c5_both_we", both, 16);

        // Reset in the middle of the first expansion, then a clean rerun.
        set_two_groups();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (276) @(negedge clk);
        chk("c6_pre_busy", busy0, 1);
        chk("c6_pre_we_label", we_label0, 1);
        chk("c6_pre_waddr", waddr0, 3);
        chk("c6_pre_wlabel", wlabel0, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("c6_we_label", we_label0, 0);
        chk("c6_we_core", we_core0, 0);
        chk("c6_busy", busy0, 0);
        chk("c6_done", done0, 0);
        chk("c6_i", i0, 0);
        chk("c6_j", j0, 0);
        chk("c6_ncl", ncl0, 0);
        rst = 1'b1;
        @(negedge clk);
        run(0, cyc, both, fovf);
        chk("c6_labels", lvec(0), 64'h2222_2222_1111_1111);
        chk("c6_ncl_rerun", ncl0, 2);
        chk("c6_cycles", cyc, 610);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
